// File: rtl/dct_seq_pkg.sv
// Shared types and helpers for the DCT block sequencer: state encoding,
// default block geometry and the end-of-block position test.
package dct_seq_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    LOAD  = 1'b1
  } seq_state_t;

  localparam int BLK_W_DEF = 8;
  localparam int BLK_H_DEF = 8;
  localparam int BLK_N     = BLK_W_DEF * BLK_H_DEF;
  localparam int X_W       = $clog2(BLK_W_DEF);
  localparam int Y_W       = $clog2(BLK_H_DEF);

  function automatic logic last_pos(input int x, input int y, input int w, input int h);
    return (x == w - 1) && (y == h - 1);
  endfunction

endpackage

// File: rtl/dct_pos_counter.sv
// Raster x/y position counter for one pixel block; wraps (BLK_W-1,BLK_H-1) -> (0,0).
module dct_pos_counter
  import dct_seq_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int BLK_H = BLK_H_DEF,
  localparam int XW = $clog2(BLK_W),
  localparam int YW = $clog2(BLK_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == XW'(BLK_W - 1)) begin
        x <= '0;
        y <= (y == YW'(BLK_H - 1)) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last = last_pos(32'(x), 32'(y), BLK_W, BLK_H);

endmodule

// File: rtl/dct_block_sequencer.sv
// Sequencer for one DCT block's shared accumulators and coef output registers.
// Optional macro DCT_BLOCK_SEQ_OVERLAP_EN: accumulate the next block while the previous one drains.
module dct_block_sequencer
  import dct_seq_pkg::*;
#(
  parameter int BLK_W  = BLK_W_DEF,
  parameter int BLK_H  = BLK_H_DEF,
  parameter int BCNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [$clog2(BLK_W)-1:0]  x_idx,
  output logic [$clog2(BLK_H)-1:0]  y_idx,
  output logic                      acc_en,
  output logic                      acc_clr,
  output logic                      out_load,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic [BCNT_W-1:0]         blk_cnt
);

  seq_state_t state, state_nxt;
  logic accept, last, hs, load_fire, ready_ok;
  logic blk_valid_q;
  logic [BCNT_W-1:0] blk_cnt_q;

  dct_pos_counter #(.BLK_W(BLK_W), .BLK_H(BLK_H)) u_pos (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (accept),
    .clr  (load_fire),
    .x    (x_idx),
    .y    (y_idx),
    .last (last)
  );

`ifdef DCT_BLOCK_SEQ_OVERLAP_EN
  // Only the closing pixel must wait: it triggers LOAD, which overwrites the coef registers.
  assign ready_ok = !(blk_valid_q && !blk_ready && last);
`else
  assign ready_ok = !blk_valid_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && last) state_nxt = LOAD;
      LOAD:  if (ena)            state_nxt = ACCUM;
      default:                   state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    din_ready = 1'b0;
    out_load  = 1'b0;
    case (state)
      ACCUM:   din_ready = ena && ready_ok;
      LOAD:    out_load  = ena;
      default: ;
    endcase
  end

  assign accept    = din_valid && din_ready;
  assign acc_en    = accept;
  assign acc_clr   = accept && (x_idx == '0) && (y_idx == '0);
  assign load_fire = out_load;
  assign hs        = ena && blk_valid_q && blk_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_valid_q <= 1'b0;
      blk_cnt_q   <= '0;
    end else begin
      if (load_fire)  blk_valid_q <= 1'b1;
      else if (hs)    blk_valid_q <= 1'b0;
      if (hs)         blk_cnt_q   <= blk_cnt_q + 1'b1;
    end
  end

  assign blk_valid = blk_valid_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Scoreboard bench for dct_block_sequencer: a pixel/block-count model predicts each cycle's outputs.
module tb_dct_block_sequencer;
  localparam int BW = 8;
  localparam int BH = 8;
  localparam int BN = BW * BH;
  localparam int CW = 16;
`ifdef DCT_BLOCK_SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, ena, din_valid, blk_ready;
  logic din_ready, acc_en, acc_clr, out_load, blk_valid;
  logic [2:0] x_idx, y_idx;
  logic [CW-1:0] blk_cnt;

  always #5 clk = ~clk;

  dct_block_sequencer #(.BLK_W(BW), .BLK_H(BH), .BCNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din_valid(din_valid), .din_ready(din_ready),
    .x_idx(x_idx), .y_idx(y_idx), .acc_en(acc_en), .acc_clr(acc_clr), .out_load(out_load),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_cnt(blk_cnt)
  );

  typedef struct {
    bit rdy, acc, clr, oload, hs, bv;
    int x, y;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model: pixels taken in the current block, a pending load, an undrained block, handoff count.
  int m_pix;
  bit m_load, m_bv;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pix = 0; m_load = 0; m_bv = 0; m_cnt = '0;
  endtask

  task automatic cycle(input bit e, input bit dv, input bit br);
    exp_t x;
    @(negedge clk);
    ena = e; din_valid = dv; blk_ready = br;
    #1;
    x.rdy   = e && !m_load && (OVL ? !(m_bv && !br && m_pix == BN - 1) : !m_bv);
    x.acc   = dv && x.rdy;
    x.clr   = x.acc && (m_pix == 0);
    x.x     = m_pix % BW;
    x.y     = m_pix / BW;
    x.oload = e && m_load;
    x.hs    = e && m_bv && br;
    x.bv    = m_bv;
    x.cnt   = m_cnt;
    exp_q.push_back(x);
    if (x.acc) begin
      m_pix++;
      if (m_pix == BN) begin m_pix = 0; m_load = 1; end
    end
    if (x.hs) begin m_bv = 0; m_cnt = m_cnt + 1'b1; end
    if (x.oload) begin m_load = 0; m_bv = 1; end
  endtask

  // Monitor: compare DUT outputs against the queued expectation for each driven cycle.
  initial begin
    exp_t e;
    int n_acc;
    n_acc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) n_acc = 0;
      else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("din_ready", din_ready, e.rdy);
        chk("blk_valid", blk_valid, e.bv);
        chk("out_load", out_load, e.oload);
        chk("acc_en", acc_en, e.acc);
        chk("acc_clr", acc_clr, e.clr);
        if (e.acc) begin
          chk("x_idx", x_idx, e.x);
          chk("y_idx", y_idx, e.y);
        end
        if (e.hs) chk("blk_cnt_at_handoff", blk_cnt, e.cnt);
        if (acc_en) n_acc++;
        if (out_load) begin
          chk("acc_per_block", n_acc, BN);
          n_acc = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; din_valid = 1'b0; blk_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_x", x_idx, 0);
    chk("rst_y", y_idx, 0);
    chk("rst_out_load", out_load, 0);
    chk("rst_din_ready", din_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with the consumer always ready
    repeat (140) cycle(1, 1, 1);

    // Consumer stalls after a block becomes valid
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 200 && !m_bv; i++) cycle(1, 1, 0);
      if (!m_bv) chk("wait_blk_valid_timeout", 0, 1);
      repeat (r == 0 ? 20 : 80) cycle(1, 1, 0);
      cycle(1, 1, 1);
    end

    // ena low at pixel 30 and during the LOAD cycle
    for (int i = 0; i < 200 && m_pix != 30; i++) cycle(1, 1, 1);
    chk("reach_pixel30", m_pix, 30);
    repeat (3) cycle(0, 1, 1);
    for (int i = 0; i < 200 && !m_load; i++) cycle(1, 1, 1);
    chk("reach_load", m_load, 1);
    repeat (2) cycle(0, 1, 1);
    repeat (20) cycle(1, 1, 1);

    // Random traffic
    repeat (800) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

    // Asynchronous reset once pixel 40 is being registered
    for (int i = 0; i < 300 && m_pix != 41; i++) cycle(1, 1, 1);
    chk("reach_pixel40", m_pix, 41);
    @(posedge clk);
    #2;
    din_valid = 1'b0;
    chk("pre_rst_x", x_idx, 41 % BW);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_blk_valid", blk_valid, 0);
    chk("async_rst_x", x_idx, 0);
    chk("async_rst_y", y_idx, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Preset the handoff counter just below wrap
    force dut.blk_cnt_q = 16'hFFFE;
    #1;
    release dut.blk_cnt_q;
    m_cnt = 16'hFFFE;
    repeat (300) cycle(1, 1, 1);
    chk("wrapped_count_model", (m_cnt < 16'h0010) ? 1 : 0, 1);

    #5;
    chk("final_blk_cnt", blk_cnt, m_cnt);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dct_block_sequencer.md
Name: dct_block_sequencer

Overview:
- Controller for one fdct_zigzag DCT block (the dct_unit coefficient accumulators and their coef output registers).
- Accepts a raster-ordered 8x8 pixel stream and produces the coefficient-ROM position (x,y), accumulator clear/enable and output-register load strobes.
- Hands each finished coefficient block to the zigzag stage over a valid/ready handshake.
- Contains no datapath. It only sequences the shared accumulators.

Parameters:
- BLK_W, 8, pixels per row; must be a power of two.
- BLK_H, 8, rows per block; must be a power of two.
- BCNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global clock enable. When low, all state freezes.
- din_valid  in  1  pixel present on the (external) datapath input.
- din_ready  out  1  sequencer accepts a pixel this cycle.
- x_idx  out  $clog2(BLK_W)  column of the current pixel; coefficient ROM select.
- y_idx  out  $clog2(BLK_H)  row of the current pixel.
- acc_en  out  1  accumulators add or load the current product.
- acc_clr  out  1  with acc_en: load instead of add (first pixel of a block).
- out_load  out  1  one-cycle strobe that copies the accumulators into the coef registers.
- blk_valid  out  1  coef registers hold an unconsumed block.
- blk_ready  in  1  zigzag stage consumes the block.
- blk_cnt  out  BCNT_W  number of blocks handed off; wraps.

Behaviour:
- Reset (async, rst_n=0):
  - state=ACCUM, pos counter=0, blk_valid=0, blk_cnt=0.
  - Combinational outputs evaluate from that state.
  - A partial block is discarded.
- Accept = din_valid & din_ready & ena.
- acc_en = accept.
- acc_clr = accept & (pos==0).
- x_idx/y_idx are the registered position, valid in the accept cycle.
- Position counter:
  - Increments on accept. x wraps at BLK_W-1 and increments y.
  - Wraps from (BLK_W-1, BLK_H-1) to (0,0).
- States:
  - ACCUM: din_ready=1 (subject to ena and the overlap rules).
    - Accepting the last pixel (pos=BLK_W*BLK_H-1) -> LOAD.
  - LOAD: out_load=1 and din_ready=0 for exactly one cycle.
    - Next: blk_valid<=1, state -> ACCUM.
- blk_valid:
  - Set by LOAD. Cleared when blk_valid & blk_ready & ena.
  - blk_cnt increments on that handshake.
  - blk_valid must not drop without a handshake.
- Latency: last pixel accepted in cycle N; out_load in N+1; blk_valid high from N+2.
- Backpressure (no overlap): din_ready=0 whenever blk_valid=1.
  - ACCUM resumes the cycle after the handshake.
  - This gives a minimum of 2 idle input cycles per block.
- ena low:
  - din_ready=0, acc_en=0, acc_clr=0, out_load=0.
  - All registers hold. A pending LOAD is deferred until ena returns.
  - blk_ready is ignored.
- Simultaneous events:
  - blk_ready in the same cycle blk_valid is set has no effect (the handshake needs the registered blk_valid).
  - Reset during LOAD: no out_load is issued; the block is lost.

Optional Feature:
- Macro: DCT_BLOCK_SEQ_OVERLAP_EN.
- Defined:
  - din_ready stays 1 while blk_valid=1, so the next block accumulates while the zigzag stage drains the coef registers.
  - Exception: the last pixel of the next block is refused (din_ready=0) while blk_valid=1 and blk_ready=0.
  - If blk_ready=1 in the same cycle, the last pixel is accepted and LOAD follows normally.
  - Steady state: 1 idle cycle per block.
- Undefined: backpressure exactly as in Behaviour.

Decomposition:
- Package dct_seq_pkg holds:
  - the state enum (ACCUM, LOAD);
  - localparams BLK_N=BLK_W*BLK_H and the X_W/Y_W widths;
  - the function last_pos(x,y).
- One sub-module, dct_pos_counter: the x/y wrap counter with inc, clr and last outputs.

Test Plan:
1. Reset release, din_valid held 1, blk_ready=1:
   - acc_clr only with pixel 0 at x=0,y=0; x/y step raster to (7,7).
   - out_load 1 cycle after pixel 63; blk_valid high next cycle, then handshake; blk_cnt=1.
2. blk_ready=0 for 20 cycles after blk_valid:
   - Without the macro, din_ready=0 for all 20 cycles and blk_valid stays 1.
   - blk_ready=1 -> blk_cnt increments and din_ready returns next cycle.
3. With DCT_BLOCK_SEQ_OVERLAP_EN, blk_ready=0:
   - Pixels 0..62 of block 2 are accepted; pixel 63 is stalled.
   - Raising blk_ready accepts pixel 63 in the same cycle; out_load follows 1 cycle later.
4. ena toggles low for 3 cycles at pixel 30 and again in the LOAD cycle:
   - No acc_en and the counter frozen at 30; out_load is delayed until ena=1.
   - Exactly 64 acc_en per block.
5. rst_n asserted at pixel 40 (asynchronously, mid-cycle):
   - Outputs immediately show blk_valid=0 and pos 0.
   - The next accepted pixel has acc_clr=1 at x=0,y=0.
6. blk_cnt preset near wrap (BCNT_W=16, 65535 handshakes via force or a fast-forward sequence):
   - The next handshake gives blk_cnt=0.
